// File: rtl/door_pkg.sv
// Shared door state encoding and the per-door next-state rule used by both channels.
package door_pkg;

  typedef logic [1:0] door_state_t;

  localparam door_state_t CLOSED  = 2'd0;
  localparam door_state_t OPENING = 2'd1;
  localparam door_state_t OPEN    = 2'd2;
  localparam door_state_t CLOSING = 2'd3;

  function automatic door_state_t door_next(input door_state_t state, input logic press,
                                            input logic c, input logic o, input logic s);
    door_state_t nxt;
    nxt = state;
    // Limit sensors and the safety beam outrank any button press.
    if (state == OPENING && o) begin
      nxt = OPEN;
    end else if (state == CLOSING && c) begin
      nxt = CLOSED;
    end else if (state == CLOSING && s) begin
      nxt = OPENING;
    end else if (press) begin
      case (state)
        CLOSED:  nxt = OPENING;
        OPEN:    nxt = s ? OPEN : CLOSING;
        OPENING: nxt = CLOSING;
        default: nxt = OPENING;
      endcase
    end
    return nxt;
  endfunction

  function automatic logic is_moving(input door_state_t st);
    return (st == OPENING) || (st == CLOSING);
  endfunction

endpackage

// File: rtl/door_fsm.sv
// One door channel: state register, button edge detect and latched travel fault.
module door_fsm
  import door_pkg::*;
(
  input  logic        clk,
  input  logic        r,
  input  logic        b_i,
  input  logic        c_i,
  input  logic        o_i,
  input  logic        s_i,
  input  logic        fault_set_i,
  output door_state_t state_o,
  output door_state_t state_next_o,
  output logic        fault_o
);

  door_state_t state_q, state_d;
  logic        b_prev_q, fault_q, fault_d, press;

  assign press = b_i & ~b_prev_q;

  // A faulted door is frozen until a fresh press both clears the fault and moves it.
  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    if (fault_set_i) begin
      fault_d = 1'b1;
    end else if (!fault_q || press) begin
      state_d = door_next(state_q, press, c_i, o_i, s_i);
      if (press) fault_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state_q  <= c_i ? CLOSED : (o_i ? OPEN : OPENING);
      b_prev_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      b_prev_q <= b_i;
      fault_q  <= fault_d;
    end
  end

  assign state_o      = state_q;
  assign state_next_o = state_d;
  assign fault_o      = fault_q;

endmodule

// File: rtl/door_motor_scheduler.sv
// Two door channels sharing one motor supply: round-robin grant, idle gap between
// owners and a travel-time watchdog.
module door_motor_scheduler
  import door_pkg::*;
#(
  parameter int MAX_TRAVEL = 1000,
  parameter int GAP        = 2,
  parameter int CNT_W      = 10
) (
  input  logic       clk,
  input  logic       r,
  input  logic [1:0] b,
  input  logic [1:0] c,
  input  logic [1:0] o,
  input  logic [1:0] s,
  output logic [1:0] u,
  output logic [1:0] d,
  output logic [1:0] state0,
  output logic [1:0] state1,
  output logic       grant_valid,
  output logic       grant_id,
  output logic [1:0] fault
);

  localparam int GAP_W = (GAP < 1) ? 1 : $clog2(GAP + 1);

  door_state_t      st      [2];
  door_state_t      st_next [2];
  logic [1:0]       fault_set, waiting;
  logic             grant_valid_q, grant_id_q, rr_q;
  logic [GAP_W-1:0] gap_q;
  logic [CNT_W-1:0] travel_q;
  door_state_t      own_st, own_next;
  logic             timeout, release_w, reverse, pick;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_door
      door_fsm u_fsm (
        .clk          (clk),
        .r            (r),
        .b_i          (b[gi]),
        .c_i          (c[gi]),
        .o_i          (o[gi]),
        .s_i          (s[gi]),
        .fault_set_i  (fault_set[gi]),
        .state_o      (st[gi]),
        .state_next_o (st_next[gi]),
        .fault_o      (fault[gi])
      );

      assign waiting[gi]   = is_moving(st[gi]) & ~fault[gi]
                             & ~(grant_valid_q & (grant_id_q == 1'(gi)));
      assign fault_set[gi] = timeout & (grant_id_q == 1'(gi));
      assign u[gi] = (st[gi] == OPENING) & grant_valid_q & (grant_id_q == 1'(gi));
      assign d[gi] = (st[gi] == CLOSING) & grant_valid_q & (grant_id_q == 1'(gi));
    end
  endgenerate

  assign own_st    = st[grant_id_q];
  assign own_next  = st_next[grant_id_q];
  assign timeout   = grant_valid_q && (travel_q == CNT_W'(MAX_TRAVEL - 1));
  assign release_w = grant_valid_q && (timeout || own_next == OPEN || own_next == CLOSED);
  assign reverse   = is_moving(own_st) && is_moving(own_next) && (own_st != own_next);
  assign pick      = (&waiting) ? rr_q : waiting[1];

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      grant_valid_q <= 1'b0;
      grant_id_q    <= 1'b0;
      rr_q          <= 1'b0;
      gap_q         <= '0;
      travel_q      <= '0;
    end else if (grant_valid_q) begin
      if (release_w) begin
        grant_valid_q <= 1'b0;
        gap_q         <= GAP_W'(GAP);
        travel_q      <= '0;
      end else begin
        // A reversal restarts the travel budget for the new direction.
        travel_q <= reverse ? '0 : travel_q + 1'b1;
      end
    end else if (gap_q != '0) begin
      gap_q <= gap_q - 1'b1;
    end else if (|waiting) begin
      grant_valid_q <= 1'b1;
      grant_id_q    <= pick;
      rr_q          <= ~pick;
      travel_q      <= '0;
    end
  end

  assign state0      = st[0];
  assign state1      = st[1];
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_door_motor_scheduler.sv
// Directed bench for door_motor_scheduler: expectations are queued per step and
// drained against the DUT after the clock edge.
module tb_door_motor_scheduler;

  localparam int P_U = 0, P_D = 1, P_ST0 = 2, P_ST1 = 3, P_GV = 4, P_GID = 5, P_FLT = 6, P_RR = 7;
  localparam logic [1:0] S_CLOSED = 2'd0, S_OPENING = 2'd1, S_OPEN = 2'd2, S_CLOSING = 2'd3;

  logic       clk = 1'b0;
  logic       r   = 1'b0;
  logic [1:0] b = '0, c = '0, o = '0, s = '0;
  logic [1:0] u, d, state0, state1, fault;
  logic       grant_valid, grant_id;

  typedef struct {
    string      tag;
    int         sel;
    logic [1:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  door_motor_scheduler #(.MAX_TRAVEL(8), .GAP(2), .CNT_W(4)) dut (
    .clk         (clk),
    .r           (r),
    .b           (b),
    .c           (c),
    .o           (o),
    .s           (s),
    .u           (u),
    .d           (d),
    .state0      (state0),
    .state1      (state1),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic want(input string tag, input int sel, input logic [1:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    sb.push_back(e);
  endtask

  function automatic logic [1:0] probe(input int sel);
    case (sel)
      P_U:     return u;
      P_D:     return d;
      P_ST0:   return state0;
      P_ST1:   return state1;
      P_GV:    return {1'b0, grant_valid};
      P_GID:   return {1'b0, grant_id};
      P_FLT:   return fault;
      default: return {1'b0, dut.rr_q};
    endcase
  endfunction

  task automatic check_all();
    while (sb.size() > 0) begin
      exp_t       e;
      logic [1:0] obs;
      e   = sb.pop_front();
      obs = probe(e.sel);
      n_cmp++;
      assert (obs === e.exp) else begin
        n_err++;
        $error("FAIL %s: observed %b expected %b", e.tag, obs, e.exp);
      end
      $display("check %-16s observed %b expected %b", e.tag, obs, e.exp);
    end
  endtask

  task automatic do_reset(input logic [1:0] cv, input logic [1:0] ov);
    c = cv; o = ov; b = '0; s = '0;
    r = 1'b1;
    tick();
    r = 1'b0;
  endtask

  initial begin
    // Scenario 1: both doors come out of reset Opening; door 0 goes first.
    do_reset(2'b00, 2'b00);
    want("rst_st0", P_ST0, S_OPENING); want("rst_st1", P_ST1, S_OPENING);
    want("rst_gv", P_GV, 2'd0); want("rst_u", P_U, 2'b00); want("rst_d", P_D, 2'b00);
    want("rst_fault", P_FLT, 2'b00);
    check_all();
    tick();
    want("s1_gid", P_GID, 2'd0); want("s1_u", P_U, 2'b01); check_all();
    o = 2'b01;
    tick();
    want("s1_open_st0", P_ST0, S_OPEN); want("s1_open_u", P_U, 2'b00); check_all();
    tick(); want("s1_gap1_u", P_U, 2'b00); check_all();
    tick(); want("s1_gap2_u", P_U, 2'b00); check_all();
    tick(); want("s1_next_u", P_U, 2'b10); want("s1_next_gid", P_GID, 2'd1); check_all();
    r = 1'b1; #1;
    want("s1_async_u", P_U, 2'b00); want("s1_async_gv", P_GV, 2'd0);
    want("s1_async_st0", P_ST0, S_OPEN); want("s1_async_st1", P_ST1, S_OPENING);
    check_all();

    // Scenario 2: door 0 pressed while door 1 closes under the grant.
    do_reset(2'b01, 2'b10);
    b = 2'b10; tick();
    want("s2_st1", P_ST1, S_CLOSING); want("s2_gv0", P_GV, 2'd0); check_all();
    b = 2'b00; tick();
    want("s2_d", P_D, 2'b10); want("s2_gid", P_GID, 2'd1); check_all();
    b = 2'b01; c = 2'b00; tick();
    want("s2_st0", P_ST0, S_OPENING); want("s2_wait_u", P_U, 2'b00); want("s2_wait_d", P_D, 2'b10);
    check_all();
    b = 2'b00; c = 2'b10; tick();
    want("s2_closed_st1", P_ST1, S_CLOSED); want("s2_rel_d", P_D, 2'b00); want("s2_rel_u", P_U, 2'b00);
    check_all();
    tick(); want("s2_gap1_u", P_U, 2'b00); want("s2_gap1_d", P_D, 2'b00); check_all();
    tick(); want("s2_gap2_u", P_U, 2'b00); want("s2_gap2_d", P_D, 2'b00); check_all();
    tick(); want("s2_next_u", P_U, 2'b01); check_all();

    // Scenario 3: simultaneous presses, round-robin order.
    do_reset(2'b11, 2'b00);
    b = 2'b11; tick();
    want("s3_st0", P_ST0, S_OPENING); want("s3_st1", P_ST1, S_OPENING); want("s3_gv", P_GV, 2'd0);
    check_all();
    b = 2'b00; c = 2'b00; tick();
    want("s3_first_u", P_U, 2'b01); want("s3_rr1", P_RR, 2'd1); check_all();
    o = 2'b01; tick(); want("s3_rel_u", P_U, 2'b00); check_all();
    tick(); want("s3_gap1_u", P_U, 2'b00); check_all();
    tick(); want("s3_gap2_u", P_U, 2'b00); check_all();
    tick();
    want("s3_second_u", P_U, 2'b10); want("s3_second_gid", P_GID, 2'd1); want("s3_rr0", P_RR, 2'd0);
    check_all();

    // Scenario 4: safety beam reverses a closing door; reversal restarts travel budget.
    do_reset(2'b10, 2'b01);
    b = 2'b01; tick(); want("s4_closing", P_ST0, S_CLOSING); check_all();
    b = 2'b00; o = 2'b00; tick(); want("s4_d", P_D, 2'b01); check_all();
    s = 2'b01; tick();
    want("s4_rev_st0", P_ST0, S_OPENING); want("s4_rev_u", P_U, 2'b01); want("s4_rev_d", P_D, 2'b00);
    want("s4_rev_gv", P_GV, 2'd1);
    check_all();
    s = 2'b00;
    for (int i = 0; i < 7; i++) tick();
    want("s4_late_u", P_U, 2'b01); want("s4_late_fault", P_FLT, 2'b00); check_all();
    tick();
    want("s4_to_fault", P_FLT, 2'b01); want("s4_to_u", P_U, 2'b00); check_all();

    // Scenario 5: travel timeout hands the motor to the waiting door.
    do_reset(2'b00, 2'b00);
    tick(); want("s5_u", P_U, 2'b01); check_all();
    for (int i = 0; i < 7; i++) tick();
    want("s5_8th_u", P_U, 2'b01); want("s5_8th_fault", P_FLT, 2'b00); check_all();
    tick();
    want("s5_fault", P_FLT, 2'b01); want("s5_to_u", P_U, 2'b00); want("s5_to_st0", P_ST0, S_OPENING);
    want("s5_to_gv", P_GV, 2'd0);
    check_all();
    tick(); tick(); want("s5_gap_gv", P_GV, 2'd0); check_all();
    tick(); want("s5_pass_u", P_U, 2'b10); want("s5_pass_gid", P_GID, 2'd1); check_all();
    b = 2'b01; tick();
    want("s5_clr_fault", P_FLT, 2'b00); want("s5_clr_st0", P_ST0, S_CLOSING); want("s5_clr_u", P_U, 2'b10);
    check_all();
    b = 2'b00;

    // Scenario 6: obstructed open door ignores a press.
    do_reset(2'b10, 2'b01);
    s = 2'b01; b = 2'b01; tick();
    want("s6_st0", P_ST0, S_OPEN); want("s6_gv", P_GV, 2'd0); check_all();
    b = 2'b00; tick();
    want("s6_st0_hold", P_ST0, S_OPEN); want("s6_u", P_U, 2'b00); want("s6_d", P_D, 2'b00);
    check_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
